// File: rtl/uart_wb_debug_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_wb_debug_master                                            |
// | Purpose  : UART (8N1) to Wishbone classic debug master. The host sends      |
// |            'W' addr[4] data[4] or 'R' addr[4] (MSB first); the bridge runs  |
// |            one single-beat bus access and replies 'K'/'E' or data[4]/'E'.   |
// |            Unknown command bytes get '?'.                                   |
// | Ports    : wb_clk_i/wb_rst_i (async, active-low) ; uart_rx_i/uart_tx_o host |
// |            serial line ; wbm_* Wishbone classic master ; busy_o = not IDLE. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_wb_debug_master #(
   parameter int CLK_DIV = 434,
   parameter int TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        uart_rx_i,
   output logic        uart_tx_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_we_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic [2:0]  wbm_cti_o,
   output logic [1:0]  wbm_bte_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   output logic        busy_o
);

   localparam int CW = $clog2(CLK_DIV + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] DIV_HALF = CW'(CLK_DIV / 2 - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [7:0]    CMD_W    = 8'h57;
   localparam logic [7:0]    CMD_R    = 8'h52;

   // ------------------------------------------------------------------ RX
   // rx_bit: 0 = start, 1..8 = data, 9 = stop. Start bit is checked at its
   // middle, every later sample is one full bit period after the previous one.
   logic          rx_meta, rx_sync, rx_prev, rx_busy, rx_valid, rx_ferr;
   logic [3:0]    rx_bit;
   logic [CW-1:0] rx_cnt;
   logic [7:0]    rx_byte;

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_prev  <= 1'b1;
         rx_busy  <= 1'b0;
         rx_bit   <= '0;
         rx_cnt   <= '0;
         rx_byte  <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_meta  <= uart_rx_i;
         rx_sync  <= rx_meta;
         rx_prev  <= rx_sync;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         if (!rx_busy) begin
            if (rx_prev && !rx_sync) begin
               rx_busy <= 1'b1;
               rx_bit  <= '0;
               rx_cnt  <= '0;
            end
         end else if (rx_cnt == ((rx_bit == 4'd0) ? DIV_HALF : DIV_LAST)) begin
            rx_cnt <= '0;
            rx_bit <= rx_bit + 4'd1;
            if (rx_bit == 4'd0 && rx_sync)
               rx_busy <= 1'b0;                      // start bit gone high: glitch
            else if (rx_bit == 4'd9) begin
               rx_busy  <= 1'b0;
               rx_valid <= rx_sync;
               rx_ferr  <= !rx_sync;
            end else if (rx_bit != 4'd0)
               rx_byte <= {rx_sync, rx_byte[7:1]};
         end else
            rx_cnt <= rx_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------ TX
   // tx_ready is true in the last cycle of a stop bit so the next frame can
   // be loaded back-to-back without an idle cycle.
   logic          tx_active, tx_done, tx_ready, tx_load;
   logic [3:0]    tx_bit;
   logic [CW-1:0] tx_cnt;
   logic [9:0]    tx_shift;
   logic [7:0]    tx_byte;

   assign tx_done   = tx_active && tx_bit == 4'd9 && tx_cnt == DIV_LAST;
   assign tx_ready  = !tx_active || tx_done;
   assign uart_tx_o = tx_shift[0];

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         tx_active <= 1'b0;
         tx_bit    <= '0;
         tx_cnt    <= '0;
         tx_shift  <= '1;
      end else if (tx_load) begin
         tx_active <= 1'b1;
         tx_bit    <= '0;
         tx_cnt    <= '0;
         tx_shift  <= {1'b1, tx_byte, 1'b0};
      end else if (tx_active) begin
         if (tx_cnt == DIV_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= tx_bit + 4'd1;
            tx_shift <= {1'b1, tx_shift[9:1]};
            if (tx_bit == 4'd9)
               tx_active <= 1'b0;
         end else
            tx_cnt <= tx_cnt + 1'b1;
      end
   end

   // -------------------------------------------------------------- parser
   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;
   state_t        state, state_nxt;
   logic [7:0]    cmd;
   logic          is_write, resp_done;
   logic [1:0]    fcnt, resp_left;
   logic [31:0]   adr, dat, resp_buf;
   logic [TW-1:0] tcnt;

   assign tx_byte = resp_buf[31:24];

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) state <= S_IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tx_load   = 1'b0;
      case (state)
         S_IDLE: if (rx_valid) state_nxt = S_CMD;
         S_CMD:  state_nxt = (cmd == CMD_W || cmd == CMD_R) ? S_ADDR : S_RESP;
         S_ADDR: if (rx_valid && fcnt == 2'd3) state_nxt = is_write ? S_DATA : S_BUS;
         S_DATA: if (rx_valid && fcnt == 2'd3) state_nxt = S_BUS;
         S_BUS:  if (wbm_ack_i || wbm_err_i || tcnt == TO_LAST) state_nxt = S_RESP;
         S_RESP: if (tx_ready) begin
                    if (!resp_done) tx_load   = 1'b1;
                    else            state_nxt = S_IDLE;
                 end
         default: state_nxt = S_IDLE;
      endcase
      // A framing error abandons a half-received command; once the bus
      // access has started the command runs to completion.
      if (rx_ferr && state != S_BUS && state != S_RESP)
         state_nxt = S_IDLE;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         cmd       <= '0;
         is_write  <= 1'b0;
         fcnt      <= '0;
         adr       <= '0;
         dat       <= '0;
         tcnt      <= '0;
         resp_buf  <= '0;
         resp_left <= '0;
         resp_done <= 1'b0;
      end else begin
         tcnt <= (state == S_BUS) ? tcnt + 1'b1 : '0;
         case (state)
            S_IDLE: begin
               fcnt      <= '0;
               resp_done <= 1'b0;
               if (rx_valid) cmd <= rx_byte;
            end
            S_CMD: begin
               is_write  <= (cmd == CMD_W);
               resp_buf  <= {8'h3F, 24'h0};
               resp_left <= '0;
            end
            S_ADDR: if (rx_valid) begin
               adr  <= {adr[23:0], rx_byte};
               fcnt <= fcnt + 2'd1;                  // wraps to 0 for DATA
            end
            S_DATA: if (rx_valid) begin
               dat  <= {dat[23:0], rx_byte};
               fcnt <= fcnt + 2'd1;
            end
            S_BUS: begin
               // err beats ack; an ack on the timeout cycle still counts.
               if (wbm_err_i || (!wbm_ack_i && tcnt == TO_LAST)) begin
                  resp_buf  <= {8'h45, 24'h0};
                  resp_left <= '0;
               end else if (wbm_ack_i) begin
                  resp_buf  <= is_write ? {8'h4B, 24'h0} : wbm_dat_i;
                  resp_left <= is_write ? 2'd0 : 2'd3;
               end
            end
            S_RESP: if (tx_load) begin
               resp_buf <= {resp_buf[23:0], 8'h0};
               if (resp_left == 2'd0) resp_done <= 1'b1;
               else                   resp_left <= resp_left - 2'd1;
            end
            default: ;
         endcase
      end
   end

   // Bus outputs decode from the state register, so reset drops cyc at once.
   assign wbm_cyc_o = (state == S_BUS);
   assign wbm_stb_o = wbm_cyc_o;
   assign wbm_we_o  = wbm_cyc_o && is_write;
   assign wbm_sel_o = wbm_cyc_o ? 4'hF : 4'h0;
   assign wbm_adr_o = adr;
   assign wbm_dat_o = dat;
   assign wbm_cti_o = 3'b000;
   assign wbm_bte_o = 2'b00;
   assign busy_o    = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_wb_debug_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_wb_debug_master                                         |
// | Purpose  : Self-checking bench: drives host commands over serial, models a |
// |            Wishbone slave, predicts replies/bus activity from the protocol |
// |            rules and compares every cycle and every received byte.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_uart_wb_debug_master;

   localparam int CLK_DIV = 8;
   localparam int TIMEOUT = 8;
   localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_NONE = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx = 1'b1;
   logic        tx;
   logic [31:0] adr, dat_o, dat_i;
   logic [3:0]  sel;
   logic        we, cyc, stb, ack, err, busy;
   logic [2:0]  cti;
   logic [1:0]  bte;

   uart_wb_debug_master #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst_n), .uart_rx_i(rx), .uart_tx_o(tx),
      .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_we_o(we),
      .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_cti_o(cti), .wbm_bte_o(bte),
      .wbm_dat_i(dat_i), .wbm_ack_i(ack), .wbm_err_i(err), .busy_o(busy));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   logic [7:0]  exp_tx[$];
   logic [7:0]  got_log[$];
   logic [31:0] exp_adr = '0, exp_dat = '0, s_rdata = '0;
   logic        exp_we = 1'b0;
   int          exp_len = 0, exp_acc = 0, got_acc = 0;
   int          s_mode = M_ACK, s_lat = 0;

   // Reply and bus expectations derived straight from the command protocol.
   task automatic setup(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                        input int mode, input int lat, input logic [31:0] rd);
      s_mode  = mode;
      s_lat   = lat;
      s_rdata = rd;
      exp_adr = a;
      exp_dat = d;
      exp_we  = (c == 8'h57);
      exp_len = (mode == M_NONE) ? TIMEOUT : lat + 1;
      got_acc = 0;
      exp_acc = (c == 8'h57 || c == 8'h52) ? 1 : 0;
      if (c == 8'h57)
         exp_tx.push_back((mode == M_ACK) ? 8'h4B : 8'h45);
      else if (c == 8'h52) begin
         if (mode == M_ACK)
            for (int i = 3; i >= 0; i--) exp_tx.push_back(rd[8*i +: 8]);
         else
            exp_tx.push_back(8'h45);
      end else
         exp_tx.push_back(8'h3F);
   endtask

   // ------------------------------------------------------------- stimulus
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      tick(CLK_DIV);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CLK_DIV);
      end
      rx = stop;
      tick(CLK_DIV);
      rx = 1'b1;
      tick($urandom_range(0, 3));
   endtask

   task automatic send_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
      send_byte(c, 1'b1);
      if (c == 8'h57 || c == 8'h52)
         for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], 1'b1);
      if (c == 8'h57)
         for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], 1'b1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!(exp_tx.size() == 0 && !busy) && n < 15 * 10 * CLK_DIV + TIMEOUT + 50) begin
         @(negedge clk);
         n++;
      end
      chk("done_in_time", 32'(exp_tx.size() == 0 && !busy), 32'd1);
      chk("access_count", 32'(got_acc), 32'(exp_acc));
   endtask

   task automatic do_txn(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                         input int mode, input int lat, input logic [31:0] rd);
      setup(c, a, d, mode, lat, rd);
      send_cmd(c, a, d);
      wait_done();
   endtask

   // ---------------------------------------------------------- slave model
   int s_cnt = 0, late = 0;
   always @(negedge clk) begin
      ack   = 1'b0;
      err   = 1'b0;
      dat_i = $urandom;
      if (!rst_n) begin
         s_cnt = 0;
         late  = 0;
      end else if (cyc) begin
         s_cnt++;
         if (s_mode != M_NONE && s_cnt == s_lat + 1) begin
            ack   = (s_mode == M_ACK || s_mode == M_BOTH);
            err   = (s_mode == M_ERR || s_mode == M_BOTH);
            dat_i = s_rdata;
         end
      end else if (s_cnt != 0) begin
         if (s_mode == M_NONE) late = 2;   // injects a stray ack after a timeout
         s_cnt = 0;
      end else if (late > 0) begin
         late--;
         if (late == 0) ack = 1'b1;
      end
   end

   // --------------------------------------------------- bus compare process
   int  cyc_len = 0;
   logic cyc_prev = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         chk("bus_static", 32'({stb, cti, bte, sel, we && !cyc}),
             32'({cyc, 3'b000, 2'b00, cyc ? 4'hF : 4'h0, 1'b0}));
         if (cyc) begin
            if (!cyc_prev) got_acc++;
            cyc_len++;
            chk("bus_adr", adr, exp_adr);
            chk("bus_we", 32'(we), 32'(exp_we));
            if (exp_we) chk("bus_dat", dat_o, exp_dat);
            chk("busy_in_bus", 32'(busy), 32'd1);
         end else if (cyc_prev) begin
            chk("cyc_len", 32'(cyc_len), 32'(exp_len));
            cyc_len = 0;
         end
         cyc_prev = cyc;
      end else begin
         cyc_prev = 1'b0;
         cyc_len  = 0;
      end
   end

   // ----------------------------------------------------------- TX monitor
   // Every bit must hold for exactly CLK_DIV samples; reset aborts a frame.
   initial begin : tx_mon
      logic [9:0] v;
      logic       bad, aborted;
      forever begin
         @(negedge clk);
         if (rst_n && tx == 1'b0) begin
            bad = 1'b0;
            aborted = 1'b0;
            v = '0;
            for (int b = 0; b < 10; b++)
               for (int c = 0; c < CLK_DIV; c++) begin
                  if (!(b == 0 && c == 0)) @(negedge clk);
                  if (!rst_n) aborted = 1'b1;
                  if (c == 0) v[b] = tx;
                  else if (!aborted && tx !== v[b]) bad = 1'b1;
               end
            if (!aborted) begin
               chk("tx_bit_width", 32'(bad), 32'd0);
               chk("tx_start_stop", 32'({v[9], v[0]}), 32'(2'b10));
               got_log.push_back(v[8:1]);
               if (exp_tx.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL tx_unexpected: got %h expected no byte", v[8:1]);
               end else
                  chk("tx_byte", 32'(v[8:1]), 32'(exp_tx.pop_front()));
            end
         end
      end
   end

   // ----------------------------------------------------------------- main
   initial begin : main
      logic [7:0]  c;
      int          n;
      tick(5);
      rst_n = 1'b1;
      tick(3);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_cyc", 32'({cyc, stb, we}), 32'd0);
      chk("rst_adr", adr, 32'd0);
      chk("rst_dat", dat_o, 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      // Directed write, ack after 3 cycles.
      got_log.delete();
      do_txn(8'h57, 32'h0000_1000, 32'hDEAD_BEEF, M_ACK, 3, 32'h0);
      chk("w_reply_n", 32'(got_log.size()), 32'd1);
      if (got_log.size() > 0) chk("w_reply", 32'(got_log[0]), 32'h4B);

      // Directed read.
      got_log.delete();
      do_txn(8'h52, 32'h0000_1000, 32'h0, M_ACK, 1, 32'h1234_5678);
      chk("r_reply_n", 32'(got_log.size()), 32'd4);
      if (got_log.size() == 4)
         chk("r_reply", {got_log[0], got_log[1], got_log[2], got_log[3]}, 32'h1234_5678);

      // Read timeout with a late ack.
      got_log.delete();
      do_txn(8'h52, 32'h0000_2004, 32'h0, M_NONE, 0, 32'h0);
      tick(4);
      chk("to_reply", {24'h0, got_log.size() > 0 ? got_log[0] : 8'h00}, 32'h45);
      chk("to_reply_n", 32'(got_log.size()), 32'd1);

      // Unknown command.
      got_log.delete();
      do_txn(8'h00, 32'h0, 32'h0, M_ACK, 0, 32'h0);
      chk("q_reply", {24'h0, got_log.size() > 0 ? got_log[0] : 8'h00}, 32'h3F);

      // Framing error inside the address field.
      got_log.delete();
      got_acc = 0;
      send_byte(8'h52, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h11, 1'b0);
      tick(2 * CLK_DIV);
      chk("ferr_busy", 32'(busy), 32'd0);
      tick(12 * CLK_DIV);
      chk("ferr_no_reply", 32'(got_log.size()), 32'd0);
      chk("ferr_no_access", 32'(got_acc), 32'd0);

      // ack and err together on a write.
      got_log.delete();
      do_txn(8'h57, 32'hA000_0003, 32'h0102_0304, M_BOTH, 2, 32'h0);
      chk("both_reply", {24'h0, got_log.size() > 0 ? got_log[0] : 8'h00}, 32'h45);

      // Short glitch on RX.
      got_log.delete();
      rx = 1'b0;
      tick(2);
      rx = 1'b1;
      tick(4);
      chk("glitch_busy", 32'(busy), 32'd0);
      tick(12 * CLK_DIV);
      chk("glitch_no_reply", 32'(got_log.size()), 32'd0);

      // Reset while cyc is high.
      setup(8'h57, 32'h0000_0040, 32'h5555_AAAA, M_ACK, 6, 32'h0);
      send_cmd(8'h57, 32'h0000_0040, 32'h5555_AAAA);
      n = 0;
      while (!cyc && n < 200) begin @(negedge clk); n++; end
      chk("cyc_seen", 32'(cyc), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_cyc", 32'({cyc, stb, we}), 32'd0);
      chk("rst_async_tx", 32'(tx), 32'd1);
      tick(3);
      exp_tx.delete();
      rst_n = 1'b1;
      tick(3);

      // Reset in the middle of a TX frame.
      setup(8'h00, 32'h0, 32'h0, M_ACK, 0, 32'h0);
      send_cmd(8'h00, 32'h0, 32'h0);
      n = 0;
      while (tx && n < 200) begin @(negedge clk); n++; end
      chk("tx_frame_seen", 32'(tx), 32'd0);
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_tx2", 32'(tx), 32'd1);
      chk("rst_async_busy", 32'(busy), 32'd0);
      tick(3);
      exp_tx.delete();
      rst_n = 1'b1;
      tick(3);
      do_txn(8'h57, 32'h0000_0080, 32'hCAFE_F00D, M_ACK, 0, 32'h0);

      // Randomized commands against the model.
      for (int t = 0; t < 14; t++) begin
         n = $urandom_range(0, 9);
         if (n < 4)      c = 8'h57;
         else if (n < 8) c = 8'h52;
         else begin
            c = 8'($urandom_range(0, 255));
            if (c == 8'h57 || c == 8'h52) c = 8'hA5;
         end
         do_txn(c, $urandom, $urandom, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 5)), $urandom);
      end

      tick(10);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_wb_debug_master.md
Name: uart_wb_debug_master

Overview:
UART-to-Wishbone debug bridge that acts as a second bus master on the SoC interconnect, upstream of sram0, rom0 and uart0. A host PC uses it to peek and poke any address over a dedicated serial line, for example to preload SRAM while the CPU is held off. It contains its own 8N1 receiver and transmitter, a command parser FSM, and a single-beat classic Wishbone master with a bus timeout.

Parameters:
CLK_DIV, 434, wb_clk_i cycles per UART bit (50 MHz / 115200); must be >= 4
TIMEOUT, 255, maximum cycles cyc may stay asserted without ack/err before the bus access is aborted

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  reset; one clock; reset is asynchronous and active-low
uart_rx_i  in  1  host serial input, asynchronous, idle high
uart_tx_o  out  1  host serial output, idle high
wbm_adr_o  out  32  byte address
wbm_dat_o  out  32  write data
wbm_sel_o  out  4  byte selects, always 4'hF during an access
wbm_we_o  out  1  write enable
wbm_cyc_o  out  1  bus cycle
wbm_stb_o  out  1  strobe, identical to cyc
wbm_cti_o  out  3  constant 3'b000 (classic)
wbm_bte_o  out  2  constant 2'b00
wbm_dat_i  in  32  read data
wbm_ack_i  in  1  slave acknowledge
wbm_err_i  in  1  slave error
busy_o  out  1  high in every state other than IDLE

Behaviour:
- Reset values: uart_tx_o=1; cyc/stb/we=0; adr/dat/sel=0; busy_o=0; FSM=IDLE; RX and TX idle; all counters 0.
- RX:
  - uart_rx_i passes through a 2-FF synchronizer.
  - A falling edge starts a bit counter; the line is sampled at CLK_DIV/2 into the start bit.
  - If the line is high at that sample, it is a glitch and RX returns to idle.
  - 8 data bits are sampled LSB first, each CLK_DIV cycles apart, then the stop bit.
  - Stop bit 1: a 1-cycle rx_valid pulse carries the byte.
  - Stop bit 0 (framing error): the byte is discarded and the parser is forced to IDLE unless it is in BUS or RESP.
- TX:
  - Frame is start(0), 8 bits LSB first, stop(1), each bit exactly CLK_DIV cycles.
  - The next byte's start bit begins the cycle after the previous stop bit ends. There is no inter-byte gap requirement.
- Protocol. All multi-byte fields are MSB first.
  - 0x57 'W', addr[4], data[4] -> write; reply 0x4B 'K' on ack, 0x45 'E' on err or timeout.
  - 0x52 'R', addr[4] -> read; reply data[4] on ack, a single 0x45 on err or timeout.
  - Any other command byte -> reply 0x3F '?'; no bus access.
- FSM states: IDLE -> CMD decode -> ADDR (4 bytes) -> DATA (4 bytes, writes only) -> BUS -> RESP -> IDLE.
  - Byte counter is 2 bits.
  - The low 2 address bits are passed through unchanged.
- Bus access:
  - cyc/stb/we assert on the first clock after the last field byte is captured.
  - adr/dat are stable for the whole access.
  - ack or err sampled high at a rising edge drops cyc/stb/we on the next cycle (single beat, no pipelining).
  - Read data is latched on the ack edge.
  - If ack and err are high together, err wins.
  - Timeout counter runs only while cyc=1. When it reaches TIMEOUT, cyc drops and the access is treated as err.
  - A late ack after the drop is ignored.
- RESP:
  - Reply bytes are queued to TX in order.
  - The FSM returns to IDLE the cycle after the last stop bit completes.
- Bytes received during BUS or RESP are dropped silently. There is no RX buffering.
- Reset mid-operation: an asserted reset immediately clears all state.
  - cyc drops asynchronously.
  - A partially sent TX frame is abandoned and the line goes high.

Test Plan:
- Write 0x57,00,00,10,00,DE,AD,BE,EF -> one cycle with adr=0x00001000, dat=0xDEADBEEF, we=1, sel=F; slave acks after 3 cycles; cyc high exactly 4 cycles; TX returns 0x4B.
- Read 0x52,00,00,10,00 with slave returning 0x12345678 -> we=0; TX sends 0x12,0x34,0x56,0x78, each frame 10*CLK_DIV cycles.
- Read with no ack and TIMEOUT=8 -> cyc high exactly 8 cycles then low; TX sends 0x45; an ack injected 2 cycles later causes no change.
- Command 0x00 -> TX 0x3F, cyc never asserts; framing error (stop=0) in the middle of the address field -> parser back to IDLE, busy_o=0, no reply.
- ack and err asserted together on a write -> TX 0x45; RX glitch shorter than CLK_DIV/2 -> no byte received.
- wb_rst_i driven low while cyc=1 and during a TX frame -> cyc=0 and uart_tx_o=1 with no clock edge; after release, a new write completes normally.
